drv_segment_scan: RTL and testbench

//  Time-multiplexed N-digit 7-segment driver (hex, unsigned) for shared-segment displays.

---
 rtl/drv_segment_pkg.sv | 20 ++
 rtl/drv_segment_hex.sv | 34 +++
 rtl/drv_segment_scan.sv | 131 +++++++++++++
 tb/tb_drv_segment_scan.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/drv_segment_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package drv_segment_pkg;

  localparam int SEGMENT_W  = 7;
  localparam int MAX_DIGITS = 32;

  typedef logic [3:0] nibble_t;

  // Active-high one-hot of idx; an index outside the display width yields all zeros.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int idx, input int width);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    if (idx >= 0 && idx < width && idx < MAX_DIGITS) begin
      r = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/drv_segment_hex.sv
// Combinational hex-to-7-segment decoder, {g,f,e,d,c,b,a} active-high.
// Letters b and d are lowercase so they stay distinct from 8 and 0.
module drv_segment_hex
  import drv_segment_pkg::*;
(
  input  nibble_t              digit_i,
  output logic [SEGMENT_W-1:0] sgmnt_o
);

  // NOTE: the default assignment before the case keeps this block latch-free.
  always_comb begin
    sgmnt_o = 7'h00;
    unique case (digit_i)
      4'h0: sgmnt_o = 7'h3F;
      4'h1: sgmnt_o = 7'h06;
      4'h2: sgmnt_o = 7'h5B;
      4'h3: sgmnt_o = 7'h4F;
      4'h4: sgmnt_o = 7'h66;
      4'h5: sgmnt_o = 7'h6D;
      4'h6: sgmnt_o = 7'h7D;
      4'h7: sgmnt_o = 7'h07;
      4'h8: sgmnt_o = 7'h7F;
      4'h9: sgmnt_o = 7'h6F;
      4'hA: sgmnt_o = 7'h77;
      4'hB: sgmnt_o = 7'h7C;
      4'hC: sgmnt_o = 7'h39;
      4'hD: sgmnt_o = 7'h5E;
      4'hE: sgmnt_o = 7'h79;
      4'hF: sgmnt_o = 7'h71;
      default: sgmnt_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/drv_segment_scan.sv
// Time-multiplexed N-digit hex 7-segment driver with a frame-synchronised double buffer.
// Optional leading-zero blanking is enabled by defining DRV_SEGMENT_BLANK_EN.
module drv_segment_scan
  import drv_segment_pkg::*;
#(
  parameter int p_width   = 4,
  parameter int p_div     = 1000,
  parameter bit p_com_act = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  nibble_t [p_width-1:0]    i_val,
  input  logic                     i_wr,
  output logic                     o_rdy,
  output logic [SEGMENT_W-1:0]     o_drv_sgmnt,
  output logic [p_width-1:0]       o_drv_com
);

  localparam int CNT_W = $clog2(p_div);
  localparam int IDX_W = (p_width > 1) ? $clog2(p_width) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_div - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_width - 1);
  localparam logic [p_width-1:0] COM_OFF = {p_width{~p_com_act}};

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  nibble_t [p_width-1:0]  disp_q, disp_d;
  nibble_t [p_width-1:0]  pend_val_q, pend_val_d;
  logic                   pend_q, pend_d;
  logic                   rdy_q;
  logic [SEGMENT_W-1:0]   sgmnt_q, sgmnt_d;
  logic [p_width-1:0]     com_q, com_d;

  logic                   tick;
  logic                   fb;
  logic                   blank;
  nibble_t                digit_sel;
  logic [SEGMENT_W-1:0]   hex_sgmnt;
  logic [MAX_DIGITS-1:0]  com_oh;

  always_comb begin
    tick = (cnt_q == CNT_LAST);
    fb   = tick && (idx_q == IDX_LAST);

    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Handshake: o_rdy mirrors !pend, so a frame swap and a new capture never coincide.
    disp_d     = disp_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (fb && pend_q) begin
      disp_d = pend_val_q;
      pend_d = 1'b0;
    end else if (i_wr && rdy_q) begin
      pend_val_d = i_val;
      pend_d     = 1'b1;
    end
  end

  // Decode the next-state digit so the registered pattern matches the slot it lands in.
  assign digit_sel = disp_d[idx_d];

  drv_segment_hex u_hex (
    .digit_i (digit_sel),
    .sgmnt_o (hex_sgmnt)
  );

`ifdef DRV_SEGMENT_BLANK_EN
  logic lit_above;

  always_comb begin
    lit_above = 1'b0;
    for (int k = 0; k < p_width; k++) begin
      if (k >= int'(idx_d) && disp_d[k] != 4'h0) begin
        lit_above = 1'b1;
      end
    end
    blank = (idx_d != '0) && !lit_above;
  end
`else
  assign blank = 1'b0;
`endif

  assign com_oh = onehot(int'(idx_q), p_width);

  always_comb begin
    sgmnt_d = blank ? '0 : hex_sgmnt;
    // First cycle of every slot is dead so the previous digit cannot ghost onto the new one.
    if (tick) begin
      com_d = COM_OFF;
    end else if (p_com_act) begin
      com_d = com_oh[p_width-1:0];
    end else begin
      com_d = ~com_oh[p_width-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      // NOTE: display and pending buffers are reset too; a stale value must never reach the pins.
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      rdy_q      <= 1'b1;
      sgmnt_q    <= '0;
      com_q      <= COM_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      rdy_q      <= !pend_d;
      sgmnt_q    <= sgmnt_d;
      com_q      <= com_d;
    end
  end

  assign o_rdy       = rdy_q;
  assign o_drv_sgmnt = sgmnt_q;
  assign o_drv_com   = com_q;

endmodule

// File: tb/tb_drv_segment_scan.sv
// Directed bench for drv_segment_scan (4 digits, 4 clocks per slot, active-low commons).
// Expectations follow the blank or non-blank build through DRV_SEGMENT_BLANK_EN.
module tb_drv_segment_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] val;
  logic        wr;
  logic        rdy;
  logic [6:0]  sgmnt;
  logic [3:0]  com;

  int n_checks = 0;
  int n_pass   = 0;
  int n        = 0;

  drv_segment_scan #(
    .p_width   (4),
    .p_div     (4),
    .p_com_act (1'b0)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_val       (val),
    .i_wr        (wr),
    .o_rdy       (rdy),
    .o_drv_sgmnt (sgmnt),
    .o_drv_com   (com)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, n);
  endtask

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] digs, input int slot);
    logic [15:0] above;
    above = digs >> (4 * slot);
`ifdef DRV_SEGMENT_BLANK_EN
    if (slot > 0 && above == 16'h0) return 7'h00;
`endif
    return seg_code(above[3:0]);
  endfunction

  // n counts clock edges since reset release: slot = n/4 mod 4, phase 0 is the dead cycle.
  task automatic run_cycles(input int cnt, input string tag, input logic [15:0] digs,
                            input logic exp_rdy);
    int slot;
    int ph;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
      n++;
      slot = (n / 4) % 4;
      ph   = n % 4;
      check({tag, "_com"}, {12'h0, com}, (ph == 0) ? 16'h000F : {12'h0, ~(4'b0001 << slot)});
      check({tag, "_sgmnt"}, {9'h0, sgmnt}, {9'h0, exp_seg(digs, slot)});
      check({tag, "_rdy"}, {15'h0, rdy}, {15'h0, exp_rdy});
    end
  endtask

  // Entered one cycle before a frame boundary; writes mid-frame, then checks the swap frame.
  task automatic write_show(input string tag, input logic [15:0] old_digs, input logic [15:0] new_digs);
    run_cycles(2, {tag, "_pre"}, old_digs, 1'b1);
    val = new_digs;
    wr  = 1'b1;
    run_cycles(1, {tag, "_wr"}, old_digs, 1'b0);
    wr  = 1'b0;
    run_cycles(13, {tag, "_hold"}, old_digs, 1'b0);
    run_cycles(16, {tag, "_show"}, new_digs, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    val   = 16'h0;
    wr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_com", {12'h0, com}, 16'h000F);
    check("rst_sgmnt", {9'h0, sgmnt}, 16'h0000);
    check("rst_rdy", {15'h0, rdy}, 16'h0001);
    rst_n = 1'b1;
    n = 0;

    // Idle scan of an all-zero display.
    run_cycles(20, "idle", 16'h0000, 1'b1);

    // Mid-frame write, then a second write while busy that must be dropped.
    val = 16'h1234;
    wr  = 1'b1;
    run_cycles(1, "w1", 16'h0000, 1'b0);
    wr  = 1'b0;
    run_cycles(3, "w1_hold", 16'h0000, 1'b0);
    val = 16'hFFFF;
    wr  = 1'b1;
    run_cycles(1, "w2_ign", 16'h0000, 1'b0);
    wr  = 1'b0;
    run_cycles(6, "w1_hold2", 16'h0000, 1'b0);
    run_cycles(16, "w1_show", 16'h1234, 1'b1);

    // Write presented on the frame-boundary cycle: visible one full frame later.
    val = 16'hABCD;
    wr  = 1'b1;
    run_cycles(1, "wfb", 16'h1234, 1'b0);
    wr  = 1'b0;
    run_cycles(15, "wfb_hold", 16'h1234, 1'b0);
    run_cycles(16, "wfb_show", 16'hABCD, 1'b1);

    write_show("d5", 16'hABCD, 16'h0005);
    write_show("d0", 16'h0005, 16'h0000);

    // Reset mid-slot with a write pending: immediate reset, pending value discarded.
    run_cycles(2, "rp_pre", 16'h0000, 1'b1);
    val = 16'h7777;
    wr  = 1'b1;
    run_cycles(1, "rp_wr", 16'h0000, 1'b0);
    wr  = 1'b0;
    run_cycles(5, "rp_hold", 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rp_com", {12'h0, com}, 16'h000F);
    check("rp_sgmnt", {9'h0, sgmnt}, 16'h0000);
    check("rp_rdy", {15'h0, rdy}, 16'h0001);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    run_cycles(36, "rp_after", 16'h0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
